sync_filter: RTL and testbench

SYNC_FILTER -- requirements
Module: sync_filter

---
 rtl/sync_pkg.sv | 16 +
 rtl/sync_filter_if.sv | 28 ++
 rtl/sync_filter_channel.sv | 78 +++++++
 rtl/sync_filter.sv | 63 ++++++
 tb/tb_sync_filter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_pkg.sv
// Shared limits and helpers for the multi-channel synchronizer/glitch filter.
package sync_pkg;

  localparam int MAX_WIDTH         = 32;
  localparam int MIN_STAGES        = 2;
  localparam int MAX_STAGES        = 4;
  localparam int MAX_FILTER_CYCLES = 255;

  // Stability counter width; a zero-length filter still gets a 1-bit counter.
  function automatic int cnt_width(input int filter_cycles);
    if (filter_cycles < 1)
      return 1;
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_filter_if.sv
// Channel bundle between a foreign-domain source and the synchronizer.
interface sync_filter_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] data_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic             changed_o;

  modport master (
    output data_i,
    input  data_o,
    input  rise_o,
    input  fall_o,
    input  changed_o
  );

  modport slave (
    input  data_i,
    output data_o,
    output rise_o,
    output fall_o,
    output changed_o
  );

endinterface

// File: rtl/sync_filter_channel.sv
// One channel: synchronizer chain, stability counter and registered level/edge flops.
module sync_filter_channel
  import sync_pkg::*;
#(
  parameter int   STAGES        = 2,
  parameter int   FILTER_CYCLES = 0,
  parameter logic INIT_VAL      = 1'b0
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic data_i,
  output logic data_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_next,
  output logic fall_next
);

  localparam int              CNT_W   = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_reg;

  logic             sync_val;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             data_reg;
  logic             data_next;
  logic             rise_reg;
  logic             fall_reg;

  assign sync_val = sync_reg[STAGES-1];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_reg <= {STAGES{INIT_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], data_i};
    end
  end

  // The level only moves once the synchronized value has disagreed with it
  // for FILTER_CYCLES+1 consecutive edges; any agreement restarts the count.
  always_comb begin
    cnt_next  = '0;
    data_next = data_reg;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (sync_val != data_reg) begin
      if (cnt_reg == CNT_MAX) begin
        data_next = sync_val;
        rise_next = sync_val;
        fall_next = ~sync_val;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_reg  <= '0;
      data_reg <= INIT_VAL;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      data_reg <= data_next;
      rise_reg <= rise_next;
      fall_reg <= fall_next;
    end
  end

  assign data_o = data_reg;
  assign rise_o = rise_reg;
  assign fall_o = fall_reg;

endmodule

// File: rtl/sync_filter.sv
// Multi-channel clock-domain-crossing synchronizer with per-channel glitch filter and edge pulses.
module sync_filter
  import sync_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0] INIT          = '0
) (
  input  logic         clock_i,
  input  logic         reset_n_i,
  sync_filter_if.slave bus
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("sync_filter: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end
  if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("sync_filter: STAGES %0d outside %0d..%0d", STAGES, MIN_STAGES, MAX_STAGES);
  end
  if (FILTER_CYCLES < 0 || FILTER_CYCLES > MAX_FILTER_CYCLES) begin : g_bad_filter
    $error("sync_filter: FILTER_CYCLES %0d outside 0..%0d", FILTER_CYCLES, MAX_FILTER_CYCLES);
  end

  logic [WIDTH-1:0] data_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;
  logic             changed_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    sync_filter_channel #(
      .STAGES        (STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .INIT_VAL      (INIT[gi])
    ) u_chan (
      .clock_i   (clock_i),
      .reset_n_i (reset_n_i),
      .data_i    (bus.data_i[gi]),
      .data_o    (data_vec[gi]),
      .rise_o    (rise_vec[gi]),
      .fall_o    (fall_vec[gi]),
      .rise_next (rise_next[gi]),
      .fall_next (fall_next[gi])
    );
  end

  // Reduced from the channels' next-state pulses so it lines up with rise_o/fall_o.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      changed_reg <= 1'b0;
    end else begin
      changed_reg <= |(rise_next | fall_next);
    end
  end

  assign bus.data_o    = data_vec;
  assign bus.rise_o    = rise_vec;
  assign bus.fall_o    = fall_vec;
  assign bus.changed_o = changed_reg;

endmodule

// File: tb/tb_sync_filter.sv
// Bench for sync_filter: five configurations under one clock, a window-based reference model and directed literal checks.
module tb_sync_filter;

  localparam int NI = 5;
  localparam int P_W [NI] = '{1, 1, 8, 1, 1};
  localparam int P_S [NI] = '{2, 3, 2, 2, 2};
  localparam int P_F [NI] = '{0, 4, 0, 10, 2};
  localparam logic [7:0] P_INIT [NI] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] din [NI];

  logic [7:0] act_d [NI];
  logic [7:0] act_r [NI];
  logic [7:0] act_f [NI];
  logic       act_ch [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_filter_if #(.WIDTH(1)) if0 ();
  sync_filter_if #(.WIDTH(1)) if1 ();
  sync_filter_if #(.WIDTH(8)) if2 ();
  sync_filter_if #(.WIDTH(1)) if3 ();
  sync_filter_if #(.WIDTH(1)) if4 ();

  sync_filter #(.WIDTH(1), .STAGES(2), .FILTER_CYCLES(0), .INIT(1'b0)) u0 (
    .clock_i(clk), .reset_n_i(rst_n), .bus(if0));
  sync_filter #(.WIDTH(1), .STAGES(3), .FILTER_CYCLES(4), .INIT(1'b0)) u1 (
    .clock_i(clk), .reset_n_i(rst_n), .bus(if1));
  sync_filter #(.WIDTH(8), .STAGES(2), .FILTER_CYCLES(0), .INIT(8'h00)) u2 (
    .clock_i(clk), .reset_n_i(rst_n), .bus(if2));
  sync_filter #(.WIDTH(1), .STAGES(2), .FILTER_CYCLES(10), .INIT(1'b0)) u3 (
    .clock_i(clk), .reset_n_i(rst_n), .bus(if3));
  sync_filter #(.WIDTH(1), .STAGES(2), .FILTER_CYCLES(2), .INIT(1'b1)) u4 (
    .clock_i(clk), .reset_n_i(rst_n), .bus(if4));

  assign if0.data_i = din[0][0];
  assign if1.data_i = din[1][0];
  assign if2.data_i = din[2];
  assign if3.data_i = din[3][0];
  assign if4.data_i = din[4][0];

  assign act_d[0] = {7'b0, if0.data_o};
  assign act_d[1] = {7'b0, if1.data_o};
  assign act_d[2] = if2.data_o;
  assign act_d[3] = {7'b0, if3.data_o};
  assign act_d[4] = {7'b0, if4.data_o};
  assign act_r[0] = {7'b0, if0.rise_o};
  assign act_r[1] = {7'b0, if1.rise_o};
  assign act_r[2] = if2.rise_o;
  assign act_r[3] = {7'b0, if3.rise_o};
  assign act_r[4] = {7'b0, if4.rise_o};
  assign act_f[0] = {7'b0, if0.fall_o};
  assign act_f[1] = {7'b0, if1.fall_o};
  assign act_f[2] = if2.fall_o;
  assign act_f[3] = {7'b0, if3.fall_o};
  assign act_f[4] = {7'b0, if4.fall_o};
  assign act_ch[0] = if0.changed_o;
  assign act_ch[1] = if1.changed_o;
  assign act_ch[2] = if2.changed_o;
  assign act_ch[3] = if3.changed_o;
  assign act_ch[4] = if4.changed_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the level flips at an edge when the synchronized value
  // seen over the last FILTER_CYCLES+1 edges all disagree with it.
  // hist[i][b][j] holds the data_i sample taken j+1 edges ago.
  logic [31:0] hist [NI][8];
  logic [7:0]  m_lvl [NI];
  logic [7:0]  m_rise [NI];
  logic [7:0]  m_fall [NI];
  logic        m_ch [NI];
  logic        rst_prev;
  logic [7:0]  din_prev [NI];

  task automatic model_reset();
    logic [7:0] iv;
    for (int i = 0; i < NI; i++) begin
      iv = P_INIT[i];
      for (int b = 0; b < 8; b++) hist[i][b] = {32{iv[b]}};
      m_lvl[i]  = iv;
      m_rise[i] = 8'h00;
      m_fall[i] = 8'h00;
      m_ch[i]   = 1'b0;
    end
  endtask

  task automatic model_step();
    logic all_diff;
    for (int i = 0; i < NI; i++) begin
      m_rise[i] = 8'h00;
      m_fall[i] = 8'h00;
      for (int b = 0; b < P_W[i]; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j <= P_F[i]; j++)
          if (hist[i][b][P_S[i] - 1 + j] == m_lvl[i][b]) all_diff = 1'b0;
        m_rise[i][b] = all_diff & ~m_lvl[i][b];
        m_fall[i][b] = all_diff & m_lvl[i][b];
        if (all_diff) m_lvl[i][b] = ~m_lvl[i][b];
        hist[i][b] = {hist[i][b][30:0], din_prev[i][b]};
      end
      m_ch[i] = |(m_rise[i] | m_fall[i]);
    end
  endtask

  initial begin
    rst_prev = 1'b0;
    for (int i = 0; i < NI; i++) din_prev[i] = 8'h00;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_prev) model_reset();
      else model_step();
      if (!rst_n) model_reset();
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("model u%0d data_o", i), act_d[i], m_lvl[i]);
        chk($sformatf("model u%0d rise_o", i), act_r[i], m_rise[i]);
        chk($sformatf("model u%0d fall_o", i), act_f[i], m_fall[i]);
        chk($sformatf("model u%0d changed_o", i), act_ch[i], m_ch[i]);
      end
      rst_prev = rst_n;
      for (int i = 0; i < NI; i++) din_prev[i] = din[i];
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) din[i] = 8'h00;
    rst_n = 1'b0;
    repeat (3) tick();
    $display("reset hold: u4 data_o=%0h u0 data_o=%0h", act_d[4], act_d[0]);
    chk("reset u4 data_o INIT", act_d[4], 8'h01);
    chk("reset u0 data_o INIT", act_d[0], 8'h00);
    chk("reset u2 rise_o", act_r[2], 8'h00);
    chk("reset u2 changed_o", act_ch[2], 1'b0);

    // Release with u0 rising and u4 held opposite to its INIT.
    rst_n = 1'b1;
    din[0] = 8'h01;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (e == 1) chk("u0 data_o edge1", act_d[0], 8'h00);
      if (e == 2) begin
        chk("u0 data_o edge2", act_d[0], 8'h01);
        chk("u0 rise_o edge2", act_r[0], 8'h01);
      end
      if (e == 3) begin
        chk("u0 rise_o edge3", act_r[0], 8'h00);
        chk("u4 data_o edge3", act_d[4], 8'h01);
      end
      if (e == 4) begin
        chk("u4 fall_o edge4", act_f[4], 8'h01);
        chk("u4 data_o edge4", act_d[4], 8'h00);
      end
      if (e == 5) chk("u4 fall_o edge5", act_f[4], 8'h00);
    end
    $display("release phase done: u0 data_o=%0h u4 data_o=%0h", act_d[0], act_d[4]);

    // u1: a 4-cycle pulse is rejected by a 4-cycle filter.
    din[1] = 8'h01;
    repeat (4) tick();
    din[1] = 8'h00;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk("u1 short pulse data_o", act_d[1], 8'h00);
      chk("u1 short pulse rise_o", act_r[1], 8'h00);
    end
    $display("short pulse phase done: u1 data_o=%0h", act_d[1]);

    din[1] = 8'h01;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (e == 6) chk("u1 data_o edge6", act_d[1], 8'h00);
      if (e == 7) begin
        chk("u1 data_o edge7", act_d[1], 8'h01);
        chk("u1 rise_o edge7", act_r[1], 8'h01);
      end
      if (e == 8) chk("u1 rise_o edge8", act_r[1], 8'h00);
    end
    din[1] = 8'h00;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (e == 7) begin
        chk("u1 fall_o edge7", act_f[1], 8'h01);
        chk("u1 data_o fall edge7", act_d[1], 8'h00);
      end
      if (e == 8) chk("u1 fall_o edge8", act_f[1], 8'h00);
    end
    $display("long pulse phase done: u1 data_o=%0h", act_d[1]);

    // u2: eight independent channels changing together.
    din[2] = 8'hA5;
    for (int e = 0; e < 4; e++) begin
      tick();
      if (e == 2) begin
        chk("u2 rise_o A5", act_r[2], 8'hA5);
        chk("u2 fall_o A5", act_f[2], 8'h00);
        chk("u2 changed_o A5", act_ch[2], 1'b1);
      end
      if (e == 3) begin
        chk("u2 rise_o after A5", act_r[2], 8'h00);
        chk("u2 changed_o after A5", act_ch[2], 1'b0);
      end
    end
    din[2] = 8'h5A;
    for (int e = 0; e < 4; e++) begin
      tick();
      if (e == 2) begin
        chk("u2 rise_o 5A", act_r[2], 8'h5A);
        chk("u2 fall_o 5A", act_f[2], 8'hA5);
        chk("u2 data_o 5A", act_d[2], 8'h5A);
        chk("u2 changed_o 5A", act_ch[2], 1'b1);
      end
    end
    $display("multi-channel phase done: u2 data_o=%0h", act_d[2]);

    // u3: reset lands while the counter sits at 6 of 10.
    din[3] = 8'h01;
    repeat (8) tick();
    chk("u3 data_o before reset", act_d[3], 8'h00);
    rst_n = 1'b0;
    tick();
    chk("u3 data_o in reset", act_d[3], 8'h00);
    chk("u3 rise_o in reset", act_r[3], 8'h00);
    chk("u4 data_o in reset", act_d[4], 8'h01);
    tick();
    rst_n = 1'b1;
    for (int e = 0; e < 16; e++) begin
      tick();
      if (e == 11) chk("u3 data_o edge11", act_d[3], 8'h00);
      if (e == 12) begin
        chk("u3 data_o edge12", act_d[3], 8'h01);
        chk("u3 rise_o edge12", act_r[3], 8'h01);
      end
      if (e == 13) chk("u3 rise_o edge13", act_r[3], 8'h00);
    end
    $display("reset abort phase done: u3 data_o=%0h", act_d[3]);

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
